// File: rtl/key_debounce_pkg.sv
// Shared types and default timing for the multi-channel key debouncer.
package key_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    // 20 ms debounce and 1 s long-press at 50 MHz
    localparam int DEF_N_KEYS          = 4;
    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_LONG_CYCLES     = 50_000_000;
    localparam int DEF_KEY_ACTIVE_LOW  = 1;

endpackage

// File: rtl/key_debounce_chan.sv
// One key channel: 2-flop synchroniser, debounce FSM, event pulses and toggle.
// Long-press detection is built when KEY_DEBOUNCE_LONG_PRESS_EN is defined.
module key_debounce_chan
    import key_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int KEY_ACTIVE_LOW  = DEF_KEY_ACTIVE_LOW
) (
    input  logic clk,
    input  logic rst,
    input  logic key_pin,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_toggle
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
    ,
    output logic key_long
`endif
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic            REL_LVL  = (KEY_ACTIVE_LOW != 0);

    if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 1) begin : g_bad_param
        $error("key_debounce_chan: DEBOUNCE_CYCLES must be >= 2 and LONG_CYCLES >= 1");
    end

    logic             sync_p0, sync_p1;
    logic             s;
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             level_nxt, press_nxt, release_nxt, toggle_nxt;
    logic             enter_pressed;

    // Synchroniser stage: idles at the released pin level out of reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= REL_LVL;
            sync_p1 <= REL_LVL;
        end else begin
            sync_p0 <= key_pin;
            sync_p1 <= sync_p0;
        end
    end

    assign s = sync_p1 ^ REL_LVL;

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        level_nxt     = key_level;
        press_nxt     = 1'b0;
        release_nxt   = 1'b0;
        toggle_nxt    = key_toggle;
        enter_pressed = 1'b0;
        case (state)
            IDLE: begin
                if (s) begin
                    state_nxt = PRESS_WAIT;
                    cnt_nxt   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_nxt = IDLE;
                end else if (cnt == CNT_MAX) begin
                    state_nxt     = PRESSED;
                    press_nxt     = 1'b1;
                    level_nxt     = 1'b1;
                    enter_pressed = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_nxt = RELEASE_WAIT;
                    cnt_nxt   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (s) begin
                    state_nxt = PRESSED;
                end else if (cnt == CNT_MAX) begin
                    state_nxt   = IDLE;
                    release_nxt = 1'b1;
                    level_nxt   = 1'b0;
                    toggle_nxt  = ~key_toggle;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // FSM and registered event outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_toggle  <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            key_level   <= level_nxt;
            key_press   <= press_nxt;
            key_release <= release_nxt;
            key_toggle  <= toggle_nxt;
        end
    end

`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
    localparam int               HCNT_W   = $clog2(LONG_CYCLES + 1);
    localparam logic [HCNT_W-1:0] HCNT_MAX = HCNT_W'(LONG_CYCLES);

    logic [HCNT_W-1:0] hcnt, hcnt_nxt;
    logic              long_nxt;

    // Hold time survives release bounces; saturation gives one pulse per press
    always_comb begin
        hcnt_nxt = hcnt;
        long_nxt = 1'b0;
        if (enter_pressed) begin
            hcnt_nxt = '0;
        end else if ((state == PRESSED || state == RELEASE_WAIT) && hcnt != HCNT_MAX) begin
            hcnt_nxt = hcnt + 1'b1;
            long_nxt = (hcnt == HCNT_MAX - 1'b1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt     <= '0;
            key_long <= 1'b0;
        end else begin
            hcnt     <= hcnt_nxt;
            key_long <= long_nxt;
        end
    end
`endif

endmodule

// File: rtl/key_debounce_multi.sv
// N independent debounced key channels. Define KEY_DEBOUNCE_LONG_PRESS_EN
// to add per-channel long-press detection and the key_long output.
module key_debounce_multi
    import key_debounce_pkg::*;
#(
    parameter int N_KEYS          = DEF_N_KEYS,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int KEY_ACTIVE_LOW  = DEF_KEY_ACTIVE_LOW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_toggle
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
    ,
    output logic [N_KEYS-1:0] key_long
`endif
);

    if (N_KEYS < 1) begin : g_bad_param
        $error("key_debounce_multi: N_KEYS must be >= 1");
    end

    for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
        key_debounce_chan #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .LONG_CYCLES    (LONG_CYCLES),
            .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .key_pin    (key_in[i]),
            .key_level  (key_level[i]),
            .key_press  (key_press[i]),
            .key_release(key_release[i]),
            .key_toggle (key_toggle[i])
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
            ,
            .key_long   (key_long[i])
`endif
        );
    end

endmodule
